// File: rtl/mix_columns_seq_pkg.sv
// ---------------------------------------------------------------------------
// mix_columns_seq_pkg
// Shared widths, FSM encoding and GF(2^8) constant multipliers for the
// sequential AES MixColumns / InvMixColumns stage.
//   STATE_W / COL_W : fixed AES state and column widths
//   GF_POLY         : low byte of the reduction polynomial 0x11B
//   state_t         : FSM encoding (IDLE = 0, BUSY = 1, DONE = 2)
//   gf_xtime, gf_mul2, gf_mul3, gf_mul9, gf_mul11, gf_mul13, gf_mul14
// ---------------------------------------------------------------------------
package mix_columns_seq_pkg;

    localparam int STATE_W = 128;
    localparam int COL_W   = 32;

    localparam logic [7:0] GF_POLY = 8'h1B;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic [7:0] gf_xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? GF_POLY : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul2(input logic [7:0] x);
        return gf_xtime(x);
    endfunction

    function automatic logic [7:0] gf_mul3(input logic [7:0] x);
        return gf_xtime(x) ^ x;
    endfunction

    // The inverse constants are built from the x2/x4/x8 xtime chain.
    function automatic logic [7:0] gf_mul9(input logic [7:0] x);
        logic [7:0] x2, x4, x8;
        x2 = gf_xtime(x);
        x4 = gf_xtime(x2);
        x8 = gf_xtime(x4);
        return x8 ^ x;
    endfunction

    function automatic logic [7:0] gf_mul11(input logic [7:0] x);
        logic [7:0] x2, x4, x8;
        x2 = gf_xtime(x);
        x4 = gf_xtime(x2);
        x8 = gf_xtime(x4);
        return x8 ^ x2 ^ x;
    endfunction

    function automatic logic [7:0] gf_mul13(input logic [7:0] x);
        logic [7:0] x2, x4, x8;
        x2 = gf_xtime(x);
        x4 = gf_xtime(x2);
        x8 = gf_xtime(x4);
        return x8 ^ x4 ^ x;
    endfunction

    function automatic logic [7:0] gf_mul14(input logic [7:0] x);
        logic [7:0] x2, x4, x8;
        x2 = gf_xtime(x);
        x4 = gf_xtime(x2);
        x8 = gf_xtime(x4);
        return x8 ^ x4 ^ x2;
    endfunction

endpackage

// File: rtl/mix_column_word.sv
// ---------------------------------------------------------------------------
// mix_column_word
// Combinational MixColumns / InvMixColumns of one 32-bit AES column.
//   col_in  [31:0] : input column, row 0 in bits [31:24]
//   inv            : 0 = forward matrix, 1 = inverse matrix
//   col_out [31:0] : transformed column, same byte layout
// ---------------------------------------------------------------------------
module mix_column_word
    import mix_columns_seq_pkg::*;
(
    input  logic [COL_W-1:0] col_in,
    input  logic             inv,
    output logic [COL_W-1:0] col_out
);

    logic [7:0] a [4];

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_row
            logic [7:0] fwd_b;
            logic [7:0] inv_b;

            assign a[gi] = col_in[COL_W-1-8*gi -: 8];

            // Row gi uses the coefficient row rotated right by gi, so the
            // diagonal coefficient always lands on a[gi].
            assign fwd_b = gf_mul2(a[gi])
                         ^ gf_mul3(a[(gi+1)%4])
                         ^ a[(gi+2)%4]
                         ^ a[(gi+3)%4];

            assign inv_b = gf_mul14(a[gi])
                         ^ gf_mul11(a[(gi+1)%4])
                         ^ gf_mul13(a[(gi+2)%4])
                         ^ gf_mul9(a[(gi+3)%4]);

            assign col_out[COL_W-1-8*gi -: 8] = inv ? inv_b : fwd_b;
        end
    endgenerate

endmodule

// File: rtl/mix_columns_seq.sv
// ---------------------------------------------------------------------------
// mix_columns_seq
// Sequential AES MixColumns / InvMixColumns: one 128-bit state is accepted,
// transformed one column per clock through a shared column datapath, then
// held until downstream takes it.
//   clk        : rising-edge clock
//   rst_n      : asynchronous active-low reset
//   in_valid   : in_state / in_inv valid
//   in_ready   : block can accept a state (IDLE only)
//   in_state   : input state, FIPS-197 byte order
//   in_inv     : 0 = MixColumns, 1 = InvMixColumns
//   out_valid  : out_state holds a finished result (DONE)
//   out_ready  : downstream accepts out_state
//   out_state  : transformed state, driven from the work register
//   busy       : high while columns are being transformed
// ---------------------------------------------------------------------------
module mix_columns_seq
    import mix_columns_seq_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [STATE_W-1:0] in_state,
    input  logic               in_inv,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [STATE_W-1:0] out_state,
    output logic               busy
);

    state_t             state_reg, state_next;
    logic [1:0]         col_cnt_reg;
    logic [STATE_W-1:0] work_reg;
    logic [STATE_W-1:0] work_next;
    logic               mode_reg;

    logic [COL_W-1:0]   cols [4];
    logic [COL_W-1:0]   col_sel;
    logic [COL_W-1:0]   col_out;

    // Column mux/demux: the selected column is replaced by its transform,
    // all other columns pass through unchanged.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_col
            assign cols[gi] = work_reg[STATE_W-1-COL_W*gi -: COL_W];
            assign work_next[STATE_W-1-COL_W*gi -: COL_W] =
                (col_cnt_reg == 2'(gi)) ? col_out : cols[gi];
        end
    endgenerate

    assign col_sel = cols[col_cnt_reg];

    mix_column_word u_mix_column_word (
        .col_in  (col_sel),
        .inv     (mode_reg),
        .col_out (col_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // in_ready is gated by rst_n so it reads 0 for the whole reset window.
    always_comb begin
        state_next = state_reg;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                in_ready = rst_n;
                if (in_valid) begin
                    state_next = ST_BUSY;
                end
            end
            ST_BUSY: begin
                busy = 1'b1;
                if (col_cnt_reg == 2'd3) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // col_cnt is 2 bits, so the last BUSY increment wraps it back to 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_cnt_reg <= 2'd0;
            work_reg    <= '0;
            mode_reg    <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (in_valid) begin
                        work_reg    <= in_state;
                        mode_reg    <= in_inv;
                        col_cnt_reg <= 2'd0;
                    end
                end
                ST_BUSY: begin
                    work_reg    <= work_next;
                    col_cnt_reg <= col_cnt_reg + 2'd1;
                end
                default: begin
                end
            endcase
        end
    end

    assign out_state = work_reg;

endmodule

// File: tb/tb_mix_columns_seq.sv
// ---------------------------------------------------------------------------
// tb_mix_columns_seq
// Directed-vector bench for mix_columns_seq with known-answer AES columns.
// ---------------------------------------------------------------------------
module tb_mix_columns_seq;

    localparam logic [127:0] F_IN   = 128'hdb135345_f20a225c_01010101_d4d4d4d5;
    localparam logic [127:0] F_OUT  = 128'h8e4da1bc_9fdc589d_01010101_d5d5d7d6;
    localparam logic [127:0] C6     = 128'hc6c6c6c6_c6c6c6c6_c6c6c6c6_c6c6c6c6;
    localparam logic [127:0] S_IN   = {32'hdb135345, 96'h0};
    localparam logic [127:0] S_OUT  = {32'h8e4da1bc, 96'h0};
    localparam logic [127:0] R_IN   = {32'h2d26314c, 96'h0};
    localparam logic [127:0] R_OUT  = {32'h4d7ebdf8, 96'h0};

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_state;
    logic         in_inv;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_state;
    logic         busy;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mix_columns_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_state  (in_state),
        .in_inv    (in_inv),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_state (out_state),
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    // Present one state, then count clock edges from the accept edge until
    // out_valid is seen (bounded).
    task automatic run_block(input logic [127:0] s, input logic inv,
                             output logic [127:0] res, output int lat);
        int w;
        w = 0;
        @(negedge clk);
        while (!in_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        check("in_ready_before_accept", 128'(in_ready), 128'd1);
        in_valid = 1'b1;
        in_state = s;
        in_inv   = inv;
        @(negedge clk);
        in_valid = 1'b0;
        in_state = ~s;
        in_inv   = ~inv;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        res = out_state;
    endtask

    task automatic take_result();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        logic [127:0] res;
        int           lat;
        logic [127:0] q_in  [3];
        logic [127:0] q_exp [3];
        logic [127:0] got_q [$];
        int           cyc_q [$];
        int           k;
        bit           pend;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_state  = '0;
        in_inv    = 1'b0;
        out_ready = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_in_ready",  128'(in_ready),  128'd0);
        check("rst_out_valid", 128'(out_valid), 128'd0);
        check("rst_busy",      128'(busy),      128'd0);
        check("rst_out_state", out_state,       128'h0);
        rst_n = 1'b1;
        #1;
        check("post_rst_in_ready", 128'(in_ready), 128'd1);

        // Forward single column and latency
        run_block(S_IN, 1'b0, res, lat);
        check("fwd_col0", res, S_OUT);
        check("latency", 128'(lat), 128'd4);
        check("done_in_ready", 128'(in_ready), 128'd0);
        take_result();
        check("idle_in_ready", 128'(in_ready), 128'd1);

        // Forward full state
        run_block(F_IN, 1'b0, res, lat);
        check("fwd_full", res, F_OUT);
        take_result();

        // Inverse returns the original
        run_block(F_OUT, 1'b1, res, lat);
        check("inv_full", res, F_IN);
        take_result();

        // c6 fixed point in both modes
        run_block(C6, 1'b0, res, lat);
        check("fwd_c6", res, C6);
        take_result();
        run_block(C6, 1'b1, res, lat);
        check("inv_c6", res, C6);
        take_result();

        // Backpressure: hold DONE for 10 cycles with in_valid pulses
        run_block(F_IN, 1'b0, res, lat);
        check("bp_first", res, F_OUT);
        for (int i = 0; i < 10; i++) begin
            in_valid = (i % 2 == 0);
            in_state = C6;
            in_inv   = 1'b1;
            @(negedge clk);
            check("bp_out_valid", 128'(out_valid), 128'd1);
            check("bp_out_state", out_state, F_OUT);
            check("bp_in_ready", 128'(in_ready), 128'd0);
        end
        in_valid = 1'b0;
        take_result();
        check("bp_release_in_ready", 128'(in_ready), 128'd1);
        check("bp_release_out_valid", 128'(out_valid), 128'd0);

        // Reset two cycles after accept
        @(negedge clk);
        in_valid = 1'b1;
        in_state = F_IN;
        in_inv   = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("mid_busy_before_rst", 128'(busy), 128'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_in_ready",  128'(in_ready),  128'd0);
        check("mid_rst_out_valid", 128'(out_valid), 128'd0);
        check("mid_rst_busy",      128'(busy),      128'd0);
        check("mid_rst_out_state", out_state,       128'h0);
        @(negedge clk);
        rst_n = 1'b1;
        run_block(R_IN, 1'b0, res, lat);
        check("post_rst_block", res, R_OUT);
        check("post_rst_latency", 128'(lat), 128'd4);
        take_result();

        // Back-to-back with in_valid held and out_ready always high
        q_in[0]  = F_IN;  q_exp[0] = F_OUT;
        q_in[1]  = C6;    q_exp[1] = C6;
        q_in[2]  = R_IN;  q_exp[2] = R_OUT;
        k    = 0;
        pend = 1'b0;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 80 && got_q.size() < 3; cyc++) begin
            @(negedge clk);
            if (pend) k++;
            pend = 1'b0;
            if (out_valid) begin
                got_q.push_back(out_state);
                cyc_q.push_back(cyc);
            end
            if (k < 3) begin
                in_valid = 1'b1;
                in_state = q_in[k];
                in_inv   = 1'b0;
            end else begin
                in_valid = 1'b0;
            end
            if (in_valid && in_ready) pend = 1'b1;
        end
        in_valid = 1'b0;
        @(negedge clk);
        out_ready = 1'b0;
        check("b2b_count", 128'(got_q.size()), 128'd3);
        for (int i = 0; i < 3 && i < got_q.size(); i++) begin
            check("b2b_result", got_q[i], q_exp[i]);
        end
        for (int i = 1; i < 3 && i < cyc_q.size(); i++) begin
            check("b2b_spacing", 128'(cyc_q[i] - cyc_q[i-1]), 128'd6);
        end
        check("b2b_end_in_ready", 128'(in_ready), 128'd1);
        check("b2b_end_busy", 128'(busy), 128'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
